pwm_ramp_controller: RTL and testbench
======================================

# pwm_ramp_controller

Sequences duty-cycle updates for the multi-channel PWM block. Host writes arrive over a valid/ready port and set a per-channel target. Once per PWM period, each channel's applied duty moves toward its target by at most `Step` counts, and all channels are committed together. The block drives the PWM duty bus directly, so duty changes are soft-started and land only on period boundaries, never mid-period.

## Interface
- `NPWM`, 5, number of PWM channels.
- `Resolution`, 8, duty width in bits per channel.
- `ChanBits`, 3, width of the channel index; must satisfy 2^ChanBits >= NPWM.
- `Step`, 4, maximum duty change per channel per period; legal range 1 to 2^Resolution-1.

- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `PeriodTick`  input  1  one-cycle pulse at each PWM period wrap.
- `WrValid`  input  1  write request.
- `WrReady`  output  1  write accepted when WrValid && WrReady.
- `WrChan`  input  ChanBits  target channel index.
- `WrDuty`  input  Resolution  target duty, unsigned.
- `DC_bus`  output  NPWM*Resolution  applied duties; channel i occupies [i*Resolution +: Resolution].
- `Settled`  output  1  high when every applied duty equals its target.
- `ChanErr`  output  1  one-cycle pulse when a write is accepted with WrChan >= NPWM.
- `Overrun`  output  1  sticky flag: a PeriodTick arrived while not in IDLE; cleared only by reset.

## Operation
- State per channel: `target[i]` and `cur[i]` (both Resolution bits). Also a commit register that drives `DC_bus`.
- FSM states:
  - IDLE → UPDATE on PeriodTick, with channel index k=0.
  - UPDATE processes channel k each cycle. After k=NPWM-1 it goes to COMMIT.
  - COMMIT → IDLE unconditionally.
- UPDATE step for channel k, in unsigned arithmetic with a Resolution+1-bit difference:
  - if `cur < target`, then `cur += min(Step, target-cur)`;
  - if `cur > target`, then `cur -= min(Step, cur-target)`;
  - otherwise `cur` is unchanged.
  - The result never overshoots the target and never wraps.
- COMMIT loads all NPWM `cur` values into `DC_bus` in a single cycle.
- Writes:
  - `WrReady` = 1 only in IDLE.
  - An accepted write with a valid channel sets `target[WrChan] = WrDuty`.
  - An accepted write with an invalid channel changes no state and pulses `ChanErr` on the next cycle.
  - Successive writes to the same channel: the last one wins.
- `Settled` is registered. It is updated in COMMIT and again on any accepted write. It goes low on the cycle after a write that makes some target differ from its `cur`.
- A PeriodTick that arrives in UPDATE or COMMIT is dropped: no state change besides `Overrun` = 1.

## Timing
- Reset values:
  - `DC_bus` = 0; all `target` and `cur` = 0.
  - FSM = IDLE.
  - `WrReady` = 1 on the first cycle after reset is deasserted.
  - `Settled` = 1, `ChanErr` = 0, `Overrun` = 0.
- Update latency: for a PeriodTick in cycle T,
  - UPDATE occupies cycles T+1..T+NPWM;
  - COMMIT occurs at T+NPWM+1;
  - new `DC_bus` is visible from T+NPWM+2.
  - `WrReady` is low from T+1 through T+NPWM+1.
- Simultaneous write and PeriodTick in IDLE: the write is accepted, and its target is used by the sweep that tick starts.
- Reset asserted mid-sweep: the next cycle is IDLE with all reset values; no partial commit is left on `DC_bus`.
- Integration requirement: the PeriodTick spacing must be at least NPWM+2 cycles. Closer spacing sets `Overrun`.
- Periods needed to move from duty a to duty b: ceil(|b-a|/Step).

## Test plan
- **Reset:** hold reset for 3 cycles. Required: `DC_bus`=0, `Settled`=1, `WrReady`=1, `Overrun`=0.
- **Ramp up:** Step=4; write ch2=10; apply PeriodTick every 20 cycles. Required: ch2 on `DC_bus` reads 4, 8, 10 after ticks 1–3. Other channels stay 0. `Settled` is 0 until the third COMMIT and 1 after it.
- **Ramp down and saturation:**
  - Write ch0=255, run 64 ticks, then write ch0=0. Required: ch0 steps 255→251→… and reaches 0 exactly after 64 more ticks.
  - Write ch0=2 with cur=0. Required: ch0 reaches 2 in one tick, with no overshoot.
- **Handshake:** hold `WrValid` high across a PeriodTick. Required:
  - the write in the tick cycle is accepted;
  - `WrReady` is low for exactly NPWM+1 cycles;
  - the held request is accepted on the first IDLE cycle afterward;
  - `DC_bus` changes only on the COMMIT-following cycle.
- **Errors:**
  - Write WrChan=7 (with NPWM=5). Required: one `ChanErr` pulse and no change to `target`, `cur` or `DC_bus`.
  - Issue a second PeriodTick 3 cycles after the first. Required: `Overrun` goes to 1 and stays set, and exactly one commit occurs.
- **Reset mid-sweep:** assert reset at T+2 after a tick. Required: `DC_bus`=0 on the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
//   Soft-start sequencer for a multi-channel PWM duty bus. The host writes
//   per-channel targets over a valid/ready port. On each PeriodTick the block
//   sweeps all channels, moving each applied duty toward its target by at
//   most Step counts. It then commits every channel to DC_bus in one cycle,
//   so the bus only changes on period boundaries.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   PeriodTick one-cycle pulse at each PWM period wrap
//   WrValid    write request
//   WrReady    write accepted when WrValid && WrReady (high only in IDLE)
//   WrChan     target channel index
//   WrDuty     target duty, unsigned
//   DC_bus     applied duties, channel i at [i*Resolution +: Resolution]
//   Settled    registered: every applied duty equals its target
//   ChanErr    one-cycle pulse after a write to a nonexistent channel
//   Overrun    sticky: PeriodTick seen outside IDLE, cleared by reset
module pwm_ramp_controller #(
  parameter int NPWM       = 5,
  parameter int Resolution = 8,
  parameter int ChanBits   = 3,
  parameter int Step       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PeriodTick,
  input  logic                         WrValid,
  output logic                         WrReady,
  input  logic [ChanBits-1:0]          WrChan,
  input  logic [Resolution-1:0]        WrDuty,
  output logic [NPWM*Resolution-1:0]   DC_bus,
  output logic                         Settled,
  output logic                         ChanErr,
  output logic                         Overrun
);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  localparam logic [Resolution:0]   STEP_W = (Resolution+1)'(Step);
  localparam logic [Resolution-1:0] STEP_R = Resolution'(Step);
  localparam logic [ChanBits:0]     NPWM_W = (ChanBits+1)'(NPWM);
  localparam logic [ChanBits-1:0]   LAST_K = ChanBits'(NPWM-1);

  state_t                state, state_nxt;
  logic [ChanBits-1:0]   k;
  logic [Resolution-1:0] target [NPWM];
  logic [Resolution-1:0] cur    [NPWM];
  logic [Resolution-1:0] dc     [NPWM];
  logic                  upd_en, commit_en;
  logic                  wr_acc, chan_ok;
  logic                  settle_wr, settle_cm;

  // One ramp step toward t, clamped so it never overshoots or wraps. The
  // difference is taken one bit wider so it cannot wrap.
  function automatic logic [Resolution-1:0] ramp(input logic [Resolution-1:0] c,
                                                 input logic [Resolution-1:0] t);
    logic [Resolution:0] diff;
    diff = '0;
    ramp = c;
    if (c < t) begin
      diff = {1'b0, t} - {1'b0, c};
      ramp = (diff > STEP_W) ? c + STEP_R : t;
    end else if (c > t) begin
      diff = {1'b0, c} - {1'b0, t};
      ramp = (diff > STEP_W) ? c - STEP_R : t;
    end
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PeriodTick) state_nxt = UPDATE;
      UPDATE:  if (k == LAST_K) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    WrReady   = (state == IDLE);
    upd_en    = (state == UPDATE);
    commit_en = (state == COMMIT);
  end

  assign wr_acc  = WrValid && WrReady;
  assign chan_ok = ({1'b0, WrChan} < NPWM_W);

  // settle_wr looks ahead to the target set as it will be after this write.
  // settle_cm uses cur as it stands after the last UPDATE.
  always_comb begin
    settle_wr = 1'b1;
    settle_cm = 1'b1;
    for (int i = 0; i < NPWM; i++) begin
      if (chan_ok && (ChanBits'(i) == WrChan)) begin
        if (WrDuty != cur[i]) settle_wr = 1'b0;
      end else if (target[i] != cur[i]) begin
        settle_wr = 1'b0;
      end
      if (target[i] != cur[i]) settle_cm = 1'b0;
    end
  end

  // Channel state, sweep index and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      Settled <= 1'b1;
      ChanErr <= 1'b0;
      Overrun <= 1'b0;
      for (int i = 0; i < NPWM; i++) begin
        target[i] <= '0;
        cur[i]    <= '0;
        dc[i]     <= '0;
      end
    end else begin
      k       <= upd_en ? k + 1'b1 : '0;
      ChanErr <= wr_acc && !chan_ok;
      // A tick outside IDLE is dropped; only this flag records it.
      if (PeriodTick && (state != IDLE)) Overrun <= 1'b1;
      for (int i = 0; i < NPWM; i++) begin
        if (wr_acc && chan_ok && (ChanBits'(i) == WrChan)) target[i] <= WrDuty;
        if (upd_en && (ChanBits'(i) == k)) cur[i] <= ramp(cur[i], target[i]);
        if (commit_en) dc[i] <= cur[i];
      end
      if (commit_en)   Settled <= settle_cm;
      else if (wr_acc) Settled <= settle_wr;
    end
  end

  always_comb begin
    DC_bus = '0;
    for (int i = 0; i < NPWM; i++) DC_bus[i*Resolution +: Resolution] = dc[i];
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed testbench for pwm_ramp_controller (NPWM=5, Resolution=8, Step=4).
module tb_pwm_ramp_controller;

  localparam int NPWM = 5;
  localparam int RES  = 8;
  localparam int CB   = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            PeriodTick = 1'b0;
  logic            WrValid = 1'b0;
  logic            WrReady;
  logic [CB-1:0]   WrChan = '0;
  logic [RES-1:0]  WrDuty = '0;
  logic [NPWM*RES-1:0] DC_bus;
  logic            Settled, ChanErr, Overrun;

  int checks = 0;
  int errors = 0;

  pwm_ramp_controller #(.NPWM(NPWM), .Resolution(RES), .ChanBits(CB), .Step(4)) dut (
    .clk(clk), .reset(reset), .PeriodTick(PeriodTick), .WrValid(WrValid),
    .WrReady(WrReady), .WrChan(WrChan), .WrDuty(WrDuty), .DC_bus(DC_bus),
    .Settled(Settled), .ChanErr(ChanErr), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ch(input int i);
    return 64'(DC_bus[i*RES +: RES]);
  endfunction

  // Inputs change just after a falling edge and are sampled on the next rising edge.
  task automatic do_write(input logic [CB-1:0] c, input logic [RES-1:0] d);
    WrValid = 1'b1; WrChan = c; WrDuty = d;
    @(negedge clk);
    WrValid = 1'b0;
  endtask

  task automatic period(input int gap);
    PeriodTick = 1'b1;
    @(negedge clk);
    PeriodTick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    int low;
    int changes;
    logic [NPWM*RES-1:0] bus_before;

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dc", 64'(DC_bus), 64'h0);
    chk("rst_settled", 64'(Settled), 64'h1);
    chk("rst_ready", 64'(WrReady), 64'h1);
    chk("rst_overrun", 64'(Overrun), 64'h0);
    chk("rst_chanerr", 64'(ChanErr), 64'h0);

    // Ramp up ch2 to 10
    do_write(3'd2, 8'd10);
    chk("up_settled_low", 64'(Settled), 64'h0);
    period(20);
    chk("up_t1", ch(2), 64'd4);
    chk("up_t1_settled", 64'(Settled), 64'h0);
    period(20);
    chk("up_t2", ch(2), 64'd8);
    chk("up_t2_settled", 64'(Settled), 64'h0);
    period(20);
    chk("up_t3", ch(2), 64'd10);
    chk("up_t3_settled", 64'(Settled), 64'h1);
    chk("up_others", 64'(DC_bus), 64'h00000A0000);

    // Ramp ch0 to full scale, then back down to 0
    do_write(3'd0, 8'd255);
    for (int n = 1; n <= 64; n++) begin
      period(10);
      if (n == 1)  chk("hi_t1", ch(0), 64'd4);
      if (n == 63) chk("hi_t63", ch(0), 64'd252);
    end
    chk("hi_t64", ch(0), 64'd255);
    do_write(3'd0, 8'd0);
    for (int n = 1; n <= 64; n++) begin
      period(10);
      if (n == 1)  chk("dn_t1", ch(0), 64'd251);
      if (n == 2)  chk("dn_t2", ch(0), 64'd247);
      if (n == 63) chk("dn_t63", ch(0), 64'd3);
    end
    chk("dn_t64", ch(0), 64'd0);
    do_write(3'd0, 8'd2);
    period(10);
    chk("small_step", ch(0), 64'd2);
    chk("small_settled", 64'(Settled), 64'h1);

    // Handshake: write held across a tick
    bus_before = DC_bus;
    WrValid = 1'b1; WrChan = 3'd1; WrDuty = 8'd20; PeriodTick = 1'b1;
    @(negedge clk);
    PeriodTick = 1'b0; WrChan = 3'd3; WrDuty = 8'd8;
    low = 0;
    changes = 0;
    while (!WrReady && low < 20) begin
      if (DC_bus !== bus_before) changes++;
      low++;
      @(negedge clk);
    end
    chk("hs_ready_low", 64'(low), 64'd6);
    chk("hs_bus_stable", 64'(changes), 64'd0);
    chk("hs_bus_commit", 64'(DC_bus), 64'h00000A0402);
    @(negedge clk);
    WrValid = 1'b0;
    chk("hs_settled", 64'(Settled), 64'h0);
    period(10);
    chk("hs_held_write", 64'(DC_bus), 64'h00040A0802);

    // Invalid channel write
    do_write(3'd7, 8'h63);
    chk("err_pulse", 64'(ChanErr), 64'h1);
    @(negedge clk);
    chk("err_pulse_end", 64'(ChanErr), 64'h0);
    chk("err_bus", 64'(DC_bus), 64'h00040A0802);
    period(10);
    chk("err_no_target", 64'(DC_bus), 64'h00080A0C02);

    // Overrun: second tick 3 cycles after the first
    chk("ovr_before", 64'(Overrun), 64'h0);
    PeriodTick = 1'b1;
    @(negedge clk);
    PeriodTick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    PeriodTick = 1'b1;
    @(negedge clk);
    PeriodTick = 1'b0;
    repeat (20) @(negedge clk);
    chk("ovr_set", 64'(Overrun), 64'h1);
    chk("ovr_one_commit", 64'(DC_bus), 64'h00080A1002);
    period(10);
    chk("ovr_sticky", 64'(Overrun), 64'h1);
    chk("ovr_next", 64'(DC_bus), 64'h00080A1402);
    chk("ovr_settled", 64'(Settled), 64'h1);

    // Reset mid-sweep
    do_write(3'd4, 8'd50);
    PeriodTick = 1'b1;
    @(negedge clk);
    PeriodTick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_dc", 64'(DC_bus), 64'h0);
    chk("mid_rst_idle", 64'(WrReady), 64'h1);
    chk("mid_rst_overrun", 64'(Overrun), 64'h0);
    chk("mid_rst_settled", 64'(Settled), 64'h1);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_commit", 64'(DC_bus), 64'h0);
    period(10);
    chk("mid_rst_targets", 64'(DC_bus), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
